mem_access_unit: RTL

- Load/store initiator between the MEM pipeline stage and the byte-addressed, word-ported data memory.
- Accepts one request at a time and converts it into data-memory word reads and writes.
- Byte and halfword stores use read-modify-write, because the memory only writes whole words.
- Load data is returned sign- or zero-extended on a single-cycle response pulse.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 66 ++++++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the load/store initiator.
//   * request op field layout (store / unsigned bits, size codes)
//   * FSM state encoding
//   * default data-memory byte-address width
//   * eff_size(): maps the reserved size code onto a word access
package mem_pkg;

  localparam int ADDR_W_DEF = 14;

  // req_op layout: bit3 store, bit2 unsigned (loads only), bits1:0 size
  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_CAP     = 3'd2,
    ST_RMW_RD  = 3'd3,
    ST_RMW_MRG = 3'd4,
    ST_WR      = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align -- combinational lane steering for the load/store unit.
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD; 3 acts as word)
//   uns       in  1   zero-extend loads instead of sign-extending
//   lane      in  2   byte lane within the word (little-endian, lane 0 = bits 7:0)
//   word      in  32  word read from memory
//   wdata     in  32  store data; byte/half data sits in the low bits
//   load_data out 32  extracted and extended load value
//   merged    out 32  memory word with the addressed byte/half replaced
// Half accesses are expected with lane 0 or 2; the caller aligns the lane.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic        sext;

  // Bring the addressed lane down to bit 0 before extension.
  assign shifted = word >> {lane, 3'b000};
  assign sext    = ~uns;

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sext & shifted[7]}},  shifted[7:0]};
      SZ_HALF: load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  // Per-byte merge: each lane either takes new store data or keeps the read byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       sel;
      logic [7:0] new_byte;

      always_comb begin
        sel      = 1'b0;
        new_byte = wdata[8*gi +: 8];
        case (size)
          SZ_BYTE: begin
            sel      = (lane == LANE);
            new_byte = wdata[7:0];
          end
          SZ_HALF: begin
            sel      = (lane[1] == LANE[1]);
            new_byte = LANE[0] ? wdata[15:8] : wdata[7:0];
          end
          default: sel = 1'b1;
        endcase
      end

      assign merged[8*gi +: 8] = sel ? new_byte : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- load/store initiator between the MEM stage and a
// byte-addressed, word-ported data memory.
//   clk, reset           clock / synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_op               bit3 store, bit2 unsigned, bits1:0 size
//   req_addr, req_wdata  byte address and store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores)
//   resp_err             misalignment trap flag
//   dm_addr, dm_wr       word-aligned memory address and write enable
//   dm_wdata, dm_rdata   memory write data / read data (read data one cycle late)
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned half/word
// accesses complete immediately with resp_err=1 and no memory access.
// Without it, misaligned addresses are forced to alignment and resp_err is 0.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  state_t state_reg, state_next;

  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] resp_rdata_reg;
  logic [DATA_W-1:0] dm_wdata_reg;

  logic       accept;
  logic [1:0] req_size;
  logic       req_store;
  logic       trap;

  logic [1:0]        size_eff;
  logic [1:0]        lane_eff;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign accept    = req_valid & req_ready;
  assign req_size  = eff_size(req_op[1:0]);
  assign req_store = req_op[OP_STORE];

`ifdef MEM_MISALIGN_TRAP_EN
  logic resp_err_reg;

  assign trap = ((req_size == SZ_HALF) & req_addr[0]) |
                ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
  assign resp_err = resp_err_reg;
`else
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state and control outputs ----------------
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    dm_wr      = 1'b0;
    resp_valid = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = ~reset;
        if (accept) begin
          if (trap) begin
            state_next = ST_RESP;
          end else if (req_store) begin
            state_next = (req_size == SZ_WORD) ? ST_WR : ST_RMW_RD;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_RD:      state_next = ST_CAP;
      ST_CAP:     state_next = ST_RESP;
      ST_RMW_RD:  state_next = ST_RMW_MRG;
      ST_RMW_MRG: state_next = ST_WR;
      ST_WR: begin
        // Gated by reset so an interrupted operation can never write.
        dm_wr      = ~reset;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = ~reset;
        state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // ---------------- lane steering ----------------
  assign size_eff = eff_size(op_reg[1:0]);

  // Misaligned half/word addresses are pulled down to their natural boundary.
  always_comb begin
    lane_eff = 2'b00;
    case (size_eff)
      SZ_BYTE: lane_eff = addr_reg[1:0];
      SZ_HALF: lane_eff = {addr_reg[1], 1'b0};
      default: lane_eff = 2'b00;
    endcase
  end

  mem_lane_align u_align (
    .size      (size_eff),
    .uns       (op_reg[OP_UNSIGNED]),
    .lane      (lane_eff),
    .word      (dm_rdata),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_rdata_reg <= '0;
      dm_wdata_reg   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      resp_err_reg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_reg         <= req_op;
        addr_reg       <= req_addr;
        wdata_reg      <= req_wdata;
        resp_rdata_reg <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
        resp_err_reg   <= trap;
`endif
        // Full-word stores skip the read phase, so load the write data now.
        if (req_store && (req_size == SZ_WORD) && !trap) begin
          dm_wdata_reg <= req_wdata;
        end
      end

      if (state_reg == ST_CAP) begin
        resp_rdata_reg <= op_reg[OP_STORE] ? '0 : load_data;
      end

      if (state_reg == ST_RMW_MRG) begin
        dm_wdata_reg <= merged;
      end
    end
  end

  // The address register also holds the memory address between requests.
  assign dm_addr    = {addr_reg[ADDR_W-1:2], 2'b00};
  assign dm_wdata   = dm_wdata_reg;
  assign resp_rdata = resp_rdata_reg;

endmodule
